// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: register-file geometry,
// requester ids and the register-index to write-enable-bit mapping.
package regfile_wr_arbiter_pkg;

    localparam int REG_COUNT = 8;
    localparam int REG_AW    = 3;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_IMM  = 2'd2,
        REQ_IO   = 2'd3
    } req_id_e;

    // r0 sits on the top enable bit, r7 on bit 0
    function automatic logic [REG_AW-1:0] reg_en_bit(input logic [REG_AW-1:0] addr);
        return REG_AW'(REG_COUNT - 1) - addr;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester/regfile-side bundle of the write arbiter; master drives requests and
// stall, slave (the arbiter) returns grants and the regfile write port.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [3*NREQ-1:0]  req_addr;
    logic [DW*NREQ-1:0] req_data;
    logic               hold;
    logic [NREQ-1:0]    gnt;
    logic [7:0]         wr_en;
    logic [DW-1:0]      wr_data;
    logic               busy;

    modport master (
        output req, req_addr, req_data, hold,
        input  gnt, wr_en, wr_data, busy
    );

    modport slave (
        input  req, req_addr, req_data, hold,
        output gnt, wr_en, wr_data, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter_decoder3_8.sv
// 3-to-8 one-hot decoder driving the regfile write enables (address 0 -> bit 7).
module decoder3_8
    import regfile_wr_arbiter_pkg::*;
(
    input  logic [REG_AW-1:0]    d,
    input  logic                 en,
    output logic [REG_COUNT-1:0] o
);
    always_comb begin
        o = '0;
        if (en) o = REG_COUNT'(1) << reg_en_bit(d);
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single regfile write port: one stage register holds
// the winning address/data, decoded to one-hot write enables unless stalled.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   gnt_q;
    logic [PTR_W-1:0]  rr_ptr;
    logic              stage_valid;
    logic [REG_AW-1:0] stage_addr;
    logic [DW-1:0]     stage_data;

    logic [NREQ-1:0]   elig;
    int                win;
    logic              have_win;
    logic [PTR_W-1:0]  win_idx;

    // First eligible requester scanning ptr, ptr+1, ... wrapping at NREQ
    function automatic int rr_pick(input logic [NREQ-1:0] e, input int ptr);
        int idx;
        rr_pick = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (ptr + k) % NREQ;
            if (e[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        // last cycle's grantee is masked so its still-high req cannot be re-granted
        elig     = bus.req & ~gnt_q & {NREQ{~bus.hold}};
        win      = rr_pick(elig, int'(rr_ptr));
        have_win = (win >= 0);
        win_idx  = have_win ? PTR_W'(win) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            rr_ptr      <= '0;
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
        end else if (have_win) begin
            gnt_q       <= NREQ'(1) << win_idx;
            stage_addr  <= bus.req_addr[REG_AW*win_idx +: REG_AW];
            stage_data  <= bus.req_data[DW*win_idx +: DW];
            stage_valid <= 1'b1;
            rr_ptr      <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
        end else begin
            gnt_q <= '0;
            // a stalled write stays staged and issues once hold drops
            if (!bus.hold) stage_valid <= 1'b0;
        end
    end

    decoder3_8 u_decoder (
        .d  (stage_addr),
        .en (stage_valid & ~bus.hold),
        .o  (bus.wr_en)
    );

    assign bus.gnt     = gnt_q;
    assign bus.wr_data = stage_data;
    assign bus.busy    = stage_valid;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for the regfile write arbiter: grant order, write decode, hold and reset.
module tb_regfile_wr_arbiter;
    import regfile_wr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    regfile_wr_arbiter_if #(.NREQ(4), .DW(8)) bus ();

    regfile_wr_arbiter #(.NREQ(4), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.hold     = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.req      = 4'b1111;
        bus.hold     = 1'b0;
        bus.req_addr = 12'hFFF;
        bus.req_data = 32'hFFFF_FFFF;
        tick();
        tick();
        vectors++;
        if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== 21'd0) begin
            $display("FAIL reset: got gnt=%b wr_en=%h wr_data=%h busy=%b, want all zero",
                     bus.gnt, bus.wr_en, bus.wr_data, bus.busy);
            errors++;
        end
        bus.req = '0;
        rst     = 1'b0;
    endtask

    task automatic test_single();
        logic [20:0] exp_v [2];
        do_reset();
        exp_v[0] = {4'b0001, 8'h80, 8'hA5, 1'b1};
        exp_v[1] = {4'b0000, 8'h00, 8'hA5, 1'b0};
        bus.req_addr[2:0] = 3'd0;
        bus.req_data[7:0] = 8'hA5;
        bus.req           = 4'b0001 << REQ_ALU;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.req = '0;
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL single cyc%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
    endtask

    task automatic test_two_req();
        logic [20:0] exp_v [4];
        do_reset();
        exp_v[0] = {4'b0001, 8'h01, 8'h11, 1'b1};
        exp_v[1] = {4'b0100, 8'h10, 8'h22, 1'b1};
        exp_v[2] = {4'b0001, 8'h01, 8'h11, 1'b1};
        exp_v[3] = {4'b0100, 8'h10, 8'h22, 1'b1};
        bus.req_addr[2:0]   = 3'd7;
        bus.req_addr[8:6]   = 3'd3;
        bus.req_data[7:0]   = 8'h11;
        bus.req_data[23:16] = 8'h22;
        bus.req             = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL two_req cyc%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
        bus.req = '0;
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_v [5];
        do_reset();
        exp_v[0] = {4'b0001, 8'h40, 8'h30, 1'b1};
        exp_v[1] = {4'b0010, 8'h20, 8'h31, 1'b1};
        exp_v[2] = {4'b0100, 8'h10, 8'h32, 1'b1};
        exp_v[3] = {4'b1000, 8'h08, 8'h33, 1'b1};
        exp_v[4] = {4'b0001, 8'h40, 8'h30, 1'b1};
        bus.req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
        bus.req_data = 32'h3332_3130;
        bus.req      = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL back_to_back cyc%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
        bus.req = '0;
    endtask

    task automatic test_hold();
        logic [20:0] exp_v [7];
        do_reset();
        exp_v[0] = {4'b0001, 8'h04, 8'h5A, 1'b1};
        exp_v[1] = {4'b0001, 8'h00, 8'h5A, 1'b1};
        exp_v[2] = {4'b0000, 8'h00, 8'h5A, 1'b1};
        exp_v[3] = {4'b0000, 8'h00, 8'h5A, 1'b1};
        exp_v[4] = {4'b0000, 8'h04, 8'h5A, 1'b1};
        exp_v[5] = {4'b0010, 8'h20, 8'h77, 1'b1};
        exp_v[6] = {4'b0000, 8'h00, 8'h77, 1'b0};
        bus.req_addr[2:0] = 3'd5;
        bus.req_data[7:0] = 8'h5A;
        bus.req           = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 2, 3, 5, 6: tick();
                1: begin
                    bus.hold          = 1'b1;
                    bus.req           = 4'b0010;
                    bus.req_addr[5:3] = 3'd2;
                    bus.req_data[15:8] = 8'h77;
                    #1;
                end
                default: begin
                    bus.hold = 1'b0;
                    #1;
                end
            endcase
            if (i == 5) bus.req = '0;
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL hold step%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [20:0] exp_v [4];
        do_reset();
        exp_v[0] = {4'b0001, 8'h80, 8'hC0, 1'b1};
        exp_v[1] = {4'b0010, 8'h40, 8'hC1, 1'b1};
        exp_v[2] = {4'b0000, 8'h00, 8'h00, 1'b0};
        exp_v[3] = {4'b0001, 8'h80, 8'hC0, 1'b1};
        bus.req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.req_data = 32'hC3C2_C1C0;
        bus.req      = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            rst = (i == 2);
            tick();
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL reset_mid_write cyc%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
        rst     = 1'b0;
        bus.req = '0;
    endtask

    task automatic test_lone_mask();
        logic [20:0] exp_v [4];
        do_reset();
        exp_v[0] = {4'b0100, 8'h02, 8'h66, 1'b1};
        exp_v[1] = {4'b0000, 8'h00, 8'h66, 1'b0};
        exp_v[2] = {4'b0100, 8'h02, 8'h66, 1'b1};
        exp_v[3] = {4'b0000, 8'h00, 8'h66, 1'b0};
        bus.req_addr[8:6]   = 3'd6;
        bus.req_data[23:16] = 8'h66;
        bus.req             = 4'b0001 << REQ_IMM;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL lone_mask cyc%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
        bus.req = '0;
    endtask

    task automatic test_same_reg();
        logic [20:0] exp_v [2];
        do_reset();
        exp_v[0] = {4'b0001, 8'h08, 8'h0A, 1'b1};
        exp_v[1] = {4'b0010, 8'h08, 8'h0B, 1'b1};
        bus.req_addr[2:0]  = 3'd4;
        bus.req_addr[5:3]  = 3'd4;
        bus.req_data[7:0]  = 8'h0A;
        bus.req_data[15:8] = 8'h0B;
        bus.req            = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.req = bus.req & ~bus.gnt;
            vectors++;
            if ({bus.gnt, bus.wr_en, bus.wr_data, bus.busy} !== exp_v[i]) begin
                $display("FAIL same_reg cyc%0d: got gnt=%b wr_en=%h wr_data=%h busy=%b, want %h",
                         i, bus.gnt, bus.wr_en, bus.wr_data, bus.busy, exp_v[i]);
                errors++;
            end
        end
        bus.req = '0;
    endtask

    initial begin
        bus.req      = '0;
        bus.hold     = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_two_req();
        test_back_to_back();
        test_hold();
        test_reset_mid_write();
        test_lone_mask();
        test_same_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
